// File: rtl/universal_shift_reg.sv
// universal_shift_reg: multi-mode shift/rotate/load register with saturating shift counter
module universal_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             drained
);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             is_shift;
    logic             is_reload;

    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];

    // next register value and shift count for the selected mode
    always_comb begin
        q_nxt = q;
        case (mode)
            3'b001: q_nxt = {q[WIDTH-2:0], ser_in_l};
            3'b010: q_nxt = {ser_in_r, q[WIDTH-1:1]};
            3'b011: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b100: q_nxt = {q[0], q[WIDTH-1:1]};
            3'b101: q_nxt = d;
            3'b110: q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            3'b111: q_nxt = '0;
            default: q_nxt = q;
        endcase
        is_shift  = mode inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
        is_reload = mode inside {3'b101, 3'b111};
        cnt_nxt   = is_reload ? '0 :
                    (is_shift && shift_cnt != FULL) ? shift_cnt + CW'(1) : shift_cnt;
    end

    // state update; drained tracks the count it is registered alongside
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= '0;
            shift_cnt <= '0;
            drained   <= 1'b0;
        end else if (en) begin
            q         <= q_nxt;
            shift_cnt <= cnt_nxt;
            drained   <= (cnt_nxt == FULL);
        end
    end
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed and randomized checks of universal_shift_reg at WIDTH 8 and 16
module tb_universal_shift_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, sl, sr;
    logic [2:0]  mode;
    logic [7:0]  d, q;
    logic        sol, sor, drn;
    logic [3:0]  cnt;

    logic        reset_w, en_w, sl_w, sr_w;
    logic [2:0]  mode_w;
    logic [15:0] d_w, q_w;
    logic        sol_w, sor_w, drn_w;
    logic [4:0]  cnt_w;

    int vectors = 0;
    int errors = 0;

    universal_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
        .ser_in_l(sl), .ser_in_r(sr), .q(q), .ser_out_l(sol), .ser_out_r(sor),
        .shift_cnt(cnt), .drained(drn)
    );

    universal_shift_reg #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset_w), .en(en_w), .mode(mode_w), .d(d_w),
        .ser_in_l(sl_w), .ser_in_r(sr_w), .q(q_w), .ser_out_l(sol_w), .ser_out_r(sor_w),
        .shift_cnt(cnt_w), .drained(drn_w)
    );

    // reference: register treated as an unsigned integer of w bits
    function automatic logic [63:0] ref_q(input int w, input logic [2:0] m, input logic [63:0] v,
                                          input logic [63:0] dd, input logic l, input logic r);
        logic [63:0] mask, top;
        mask = (64'd1 << w) - 64'd1;
        top  = (v >> (w - 1)) & 64'd1;
        case (m)
            3'd1: return ((v << 1) | 64'(l)) & mask;
            3'd2: return (v >> 1) | (64'(r) << (w - 1));
            3'd3: return ((v << 1) | top) & mask;
            3'd4: return (v >> 1) | ((v & 64'd1) << (w - 1));
            3'd5: return dd & mask;
            3'd6: return (v >> 1) | (top << (w - 1));
            3'd7: return 64'd0;
            default: return v;
        endcase
    endfunction

    function automatic int ref_cnt(input int w, input logic [2:0] m, input int c);
        if (m == 3'd5 || m == 3'd7) return 0;
        if (m == 3'd0) return c;
        return (c < w) ? c + 1 : w;
    endfunction

    task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] dd, input logic l, input logic r);
        en = e; mode = m; d = dd; sl = l; sr = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_w(input logic e, input logic [2:0] m, input logic [15:0] dd);
        en_w = e; mode_w = m; d_w = dd; sl_w = 1'($urandom); sr_w = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vectors++;
        if (q !== 8'h00 || cnt !== 4'd0 || drn !== 1'b0 || q_w !== 16'h0 || cnt_w !== 5'd0 || drn_w !== 1'b0) begin
            errors++;
            $display("FAIL reset: q=%h cnt=%0d drn=%b q_w=%h cnt_w=%0d drn_w=%b, want all zero", q, cnt, drn, q_w, cnt_w, drn_w);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        reset_w = 1'b0;
    endtask

    task automatic test_load;
        drive(1, 3'd5, 8'hA5, 1, 1);
        vectors++;
        if (q !== 8'hA5 || cnt !== 4'd0 || drn !== 1'b0) begin
            errors++;
            $display("FAIL load: q=%h cnt=%0d drn=%b, want a5 0 0", q, cnt, drn);
        end
    endtask

    task automatic test_rotate;
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'd3, 8'($urandom), 1'($urandom), 1'($urandom));
            vectors++;
            if (drn !== (i == 7) || cnt !== 4'(i + 1)) begin
                errors++;
                $display("FAIL rotate_cnt[%0d]: cnt=%0d drn=%b, want %0d %b", i, cnt, drn, i + 1, i == 7);
            end
        end
        vectors++;
        if (q !== 8'hA5) begin
            errors++;
            $display("FAIL rotate8: q=%h, want a5", q);
        end
        drive(1, 3'd3, 8'h00, 0, 0);
        vectors++;
        if (q !== 8'h4B || cnt !== 4'd8 || drn !== 1'b1) begin
            errors++;
            $display("FAIL rotate9: q=%h cnt=%0d drn=%b, want 4b 8 1", q, cnt, drn);
        end
    endtask

    task automatic test_asr;
        drive(1, 3'd5, 8'h80, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 3'd6, 8'hFF, 1'($urandom), 1'b0);
        vectors++;
        if (q !== 8'hF0 || cnt !== 4'd3) begin
            errors++;
            $display("FAIL asr: q=%h cnt=%0d, want f0 3", q, cnt);
        end
        drive(1, 3'd2, 8'hFF, 1, 0);
        vectors++;
        if (q !== 8'h78 || sor !== 1'b0 || sol !== 1'b0) begin
            errors++;
            $display("FAIL lsr: q=%h sor=%b sol=%b, want 78 0 0", q, sor, sol);
        end
    endtask

    task automatic test_shift_hold;
        logic [3:0] bits;
        bits = 4'b1101;
        drive(1, 3'd7, 8'hFF, 1, 1);
        vectors++;
        if (q !== 8'h00 || cnt !== 4'd0 || drn !== 1'b0) begin
            errors++;
            $display("FAIL clear: q=%h cnt=%0d drn=%b, want 00 0 0", q, cnt, drn);
        end
        for (int i = 0; i < 4; i++) drive(1, 3'd1, 8'hFF, bits[i], 1);
        vectors++;
        if (q !== 8'h0B || cnt !== 4'd4 || sor !== 1'b1) begin
            errors++;
            $display("FAIL shl: q=%h cnt=%0d sor=%b, want 0b 4 1", q, cnt, sor);
        end
        for (int i = 0; i < 3; i++) drive(0, 3'd5, 8'hFF, 1, 1);
        vectors++;
        if (q !== 8'h0B || cnt !== 4'd4 || drn !== 1'b0) begin
            errors++;
            $display("FAIL hold_en0: q=%h cnt=%0d drn=%b, want 0b 4 0", q, cnt, drn);
        end
        drive(1, 3'd0, 8'hFF, 1, 1);
        vectors++;
        if (q !== 8'h0B || cnt !== 4'd4) begin
            errors++;
            $display("FAIL hold_mode0: q=%h cnt=%0d, want 0b 4", q, cnt);
        end
    endtask

    task automatic test_async_reset;
        drive(1, 3'd5, 8'h3C, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 3'd1, 8'h00, 1, 0);
        #2;
        reset = 1'b1; en = 1'b1; mode = 3'd5; d = 8'hFF;
        #1;
        vectors++;
        if (q !== 8'h00 || cnt !== 4'd0 || drn !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: q=%h cnt=%0d drn=%b, want 00 0 0", q, cnt, drn);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (q !== 8'h00 || cnt !== 4'd0 || drn !== 1'b0) begin
                errors++;
                $display("FAIL reset_held[%0d]: q=%h cnt=%0d drn=%b, want 00 0 0", i, q, cnt, drn);
            end
        end
        reset = 1'b0;
        drive(1, 3'd1, 8'h00, 1, 0);
        vectors++;
        if (q !== 8'h01 || cnt !== 4'd1) begin
            errors++;
            $display("FAIL resume: q=%h cnt=%0d, want 01 1", q, cnt);
        end
    endtask

    task automatic test_wide_rotate;
        drive_w(1, 3'd5, 16'h8001);
        for (int i = 0; i < 16; i++) begin
            drive_w(1, 3'd4, 16'($urandom));
            vectors++;
            if (drn_w !== (i == 15) || cnt_w !== 5'(i + 1)) begin
                errors++;
                $display("FAIL wide_cnt[%0d]: cnt=%0d drn=%b, want %0d %b", i, cnt_w, drn_w, i + 1, i == 15);
            end
        end
        vectors++;
        if (q_w !== 16'h8001) begin
            errors++;
            $display("FAIL wide_rotate: q=%h, want 8001", q_w);
        end
        drive_w(1, 3'd4, 16'h0);
        vectors++;
        if (q_w !== 16'hC000 || cnt_w !== 5'd16 || drn_w !== 1'b1) begin
            errors++;
            $display("FAIL wide_rotate17: q=%h cnt=%0d drn=%b, want c000 16 1", q_w, cnt_w, drn_w);
        end
    endtask

    task automatic test_random;
        logic [63:0] mq, mq_w;
        int mc, mc_w;
        logic e, e_w;
        logic [2:0] m, m_w;
        logic [7:0] dd;
        logic [15:0] dd_w;
        logic l, r;
        drive(1, 3'd7, 8'h00, 0, 0);
        drive_w(1, 3'd7, 16'h0);
        mq = 0; mc = 0; mq_w = 0; mc_w = 0;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(3) != 0); m = 3'($urandom); dd = 8'($urandom);
            l = 1'($urandom); r = 1'($urandom);
            e_w = ($urandom_range(3) != 0); m_w = 3'($urandom); dd_w = 16'($urandom);
            en_w = e_w; mode_w = m_w; d_w = dd_w; sl_w = r; sr_w = l;
            drive(e, m, dd, l, r);
            if (e) begin
                mq = ref_q(8, m, mq, 64'(dd), l, r);
                mc = ref_cnt(8, m, mc);
            end
            if (e_w) begin
                mq_w = ref_q(16, m_w, mq_w, 64'(dd_w), r, l);
                mc_w = ref_cnt(16, m_w, mc_w);
            end
            vectors++;
            if (q !== mq[7:0] || cnt !== 4'(mc) || drn !== (mc == 8) || sol !== mq[7] || sor !== mq[0]) begin
                errors++;
                $display("FAIL rand8[%0d]: q=%h cnt=%0d drn=%b sol=%b sor=%b, want %h %0d %b", i, q, cnt, drn, sol, sor, mq[7:0], mc, mc == 8);
            end
            vectors++;
            if (q_w !== mq_w[15:0] || cnt_w !== 5'(mc_w) || drn_w !== (mc_w == 16) || sol_w !== mq_w[15] || sor_w !== mq_w[0]) begin
                errors++;
                $display("FAIL rand16[%0d]: q=%h cnt=%0d drn=%b, want %h %0d %b", i, q_w, cnt_w, drn_w, mq_w[15:0], mc_w, mc_w == 16);
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00; sl = 1'b0; sr = 1'b0;
        reset_w = 1'b1; en_w = 1'b0; mode_w = 3'd0; d_w = 16'h0; sl_w = 1'b0; sr_w = 1'b0;
        #2;
        test_reset;
        test_load;
        test_rotate;
        test_asr;
        test_shift_hold;
        test_async_reset;
        test_wide_rotate;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
